// File: rtl/cc1200_spi_arbiter_if.sv
// Bus bundle between the three CC1200 requesters (APB software, Tx packet
// engine, Rx packet engine), the arbiter, and the SPI engine.
//
// Handshake: a requester raises req[i] and keeps req_data/req_wr valid
// until it sees gnt[i] (it may drop req afterwards). The transaction
// always ends with exactly one done[i] pulse, with err alongside on a
// timeout. On the engine side, Start is a one-cycle pulse. The engine
// raises Busy while it works and lowers it when DataIn is valid.
//
// Requester side : req, req_data, req_wr, lock -> gnt, done, err, rdata
// SPI engine side: Start, DataOut, WR -> Busy, DataIn
// slave modport  : the arbiter
// master modport : the environment (requesters plus the SPI engine)
interface cc1200_spi_arbiter_if;
  logic [2:0]  req;
  logic [95:0] req_data;
  logic [11:0] req_wr;
  logic [2:0]  lock;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        err;
  logic [31:0] rdata;
  logic        Start;
  logic        Busy;
  logic [31:0] DataOut;
  logic [3:0]  WR;
  logic [31:0] DataIn;

  modport slave (
    input  req, req_data, req_wr, lock, Busy, DataIn,
    output gnt, done, err, rdata, Start, DataOut, WR
  );

  modport master (
    output req, req_data, req_wr, lock, Busy, DataIn,
    input  gnt, done, err, rdata, Start, DataOut, WR
  );
endinterface

// File: rtl/cc1200_spi_arbiter.sv
// Three-way arbiter in front of a single CC1200 SPI engine.
// One requester owns the engine per transaction:
//   IDLE -> START -> WAIT_BUSY -> WAIT_DONE -> DONE -> IDLE.
// Arbitration is round-robin. A locked owner that is still requesting keeps
// the engine for back-to-back bursts. WAIT_BUSY and WAIT_DONE are each
// bounded by TIMEOUT cycles. On expiry the transaction ends with err.
//
// Ports:
//   clk       - single clock, rising edge
//   rstn      - synchronous active-low reset
//   bus       - cc1200_spi_arbiter_if.slave (requester and SPI engine signals)
//   dbg_state - current FSM state encoding
module cc1200_spi_arbiter #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  rstn,
  cc1200_spi_arbiter_if.slave   bus,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  // The counter starts at zero on entry to a wait state. Its value on the
  // TIMEOUT-th cycle there is therefore TIMEOUT-1.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state_q,    state_d;
  logic [1:0]  last_q,     last_d;
  logic [15:0] cnt_q,      cnt_d;
  logic        err_flag_q, err_flag_d;
  logic [2:0]  gnt_q,      gnt_d;
  logic [31:0] dout_q,     dout_d;
  logic [3:0]  wr_q,       wr_d;
  logic [31:0] rdata_q,    rdata_d;

  logic [1:0]  win;
  logic [1:0]  cand;
  logic        found;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      last_q     <= 2'd2;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      gnt_q      <= '0;
      dout_q     <= '0;
      wr_q       <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      gnt_q      <= gnt_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state logic, including the arbitration decision
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    gnt_d      = gnt_q;
    dout_d     = dout_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;

    // A locked, still-requesting previous owner wins outright. Otherwise
    // the search runs last+1, last+2, then last itself.
    found = bus.lock[last_q] && bus.req[last_q];
    win   = last_q;
    cand  = last_q;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          gnt_d      = 3'b001 << win;
          last_d     = win;
          dout_d     = bus.req_data[32*win +: 32];
          wr_d       = bus.req_wr[4*win +: 4];
          err_flag_d = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.Busy) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_flag_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + 16'd1;
        if (!bus.Busy) begin
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_flag_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        // A timed-out transaction leaves the last good read data in place
        if (!err_flag_q) rdata_d = bus.DataIn;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus.Start   = (state_q == S_START);
    bus.done    = (state_q == S_DONE) ? gnt_q : 3'b000;
    bus.err     = (state_q == S_DONE) && err_flag_q;
    bus.gnt     = gnt_q;
    bus.DataOut = dout_q;
    bus.WR      = wr_q;
    bus.rdata   = rdata_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_cc1200_spi_arbiter.sv
module tb_cc1200_spi_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cc1200_spi_arbiter_if bus();
  logic [2:0] dbg_state;

  cc1200_spi_arbiter #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Item layout: DataOut[71:40] WR[39:36] owner[35:33] err[32] rdata[31:0]
  logic [71:0] exp_q[$];
  int          done_cyc_q[$];
  logic        rd_pend = 1'b0;
  logic [31:0] rd_exp  = '0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [71:0] mk(input logic [31:0] d, input logic [3:0] w,
                                     input logic [2:0] o, input logic e,
                                     input logic [31:0] r);
    return {d, w, o, e, r};
  endfunction

  // ---------------- SPI engine model ----------------
  // After a Start pulse, Busy is high for busy_len cycles starting in the
  // following cycle. In manual mode Busy simply follows busy_manual.
  int busy_cnt    = 0;
  int busy_len    = 1;
  bit spi_auto    = 1'b1;
  bit busy_manual = 1'b0;

  always @(negedge clk) begin
    if (spi_auto) begin
      if (busy_cnt != 0) begin
        bus.Busy = 1'b1;
        busy_cnt--;
      end else begin
        bus.Busy = 1'b0;
      end
      if (bus.Start) busy_cnt = busy_len;
    end else begin
      bus.Busy = busy_manual;
      busy_cnt = 0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [71:0] head;
    cyc++;
    if (rd_pend) begin
      chk("rdata", bus.rdata, rd_exp);
      rd_pend = 1'b0;
    end
    if (bus.Start) begin
      if (exp_q.size() == 0) begin
        chk("start_unexpected", bus.Start, 1'b0);
      end else begin
        head = exp_q[0];
        chk("gnt_onehot", $onehot(bus.gnt), 1'b1);
        chk("gnt", bus.gnt, head[35:33]);
        chk("dataout", bus.DataOut, head[71:40]);
        chk("wr", bus.WR, head[39:36]);
      end
    end
    if (bus.done != 3'b000) begin
      done_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("done_unexpected", bus.done, 3'b000);
      end else begin
        head = exp_q.pop_front();
        chk("done", bus.done, head[35:33]);
        chk("err", bus.err, head[32]);
        chk("dataout_hold", bus.DataOut, head[71:40]);
        chk("wr_hold", bus.WR, head[39:36]);
        rd_pend = 1'b1;
        rd_exp  = head[31:0];
      end
    end else begin
      if (bus.err) chk("err_without_done", bus.err, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rstn    = 1'b0;
    bus.req = '0;
    bus.lock = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.Start && n < 100);
    if (!bus.Start) chk({tag, "_start_timeout"}, 1'b0, 1'b1);
  endtask

  // Applies req in an IDLE cycle and counts cycles until done is seen.
  task automatic req_and_count(input logic [2:0] r, output int n);
    n = 0;
    bus.req = r;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) bus.req = '0;
    end while (bus.done == 3'b000 && n < 100);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rd_pend) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || rd_pend) begin
      chk({tag, "_drain_timeout"}, 72'(exp_q.size()), 72'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 3'b000);
    chk({tag, "_done"}, bus.done, 3'b000);
    chk({tag, "_err"}, bus.err, 1'b0);
    chk({tag, "_start"}, bus.Start, 1'b0);
    chk({tag, "_dataout"}, bus.DataOut, 32'h0);
    chk({tag, "_wr"}, bus.WR, 4'h0);
    chk({tag, "_rdata"}, bus.rdata, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [95:0] DATA3 = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
  localparam logic [11:0] WR3   = {4'h9, 4'h6, 4'h5};

  initial begin
    int lat;
    int d0;
    int d1;
    int d2;
    bus.req      = 3'b111;
    bus.lock     = 3'b111;
    bus.req_data = DATA3;
    bus.req_wr   = WR3;
    bus.DataIn   = 32'hFFFF_FFFF;

    // Outputs during reset, with every request input active
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    bus.req  = '0;
    bus.lock = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Single software transaction. req is dropped and the word changed
    // after the grant, and the transaction must still complete.
    busy_len     = 5;
    bus.req_data = {64'h0, 32'hA5A5_0001};
    bus.req_wr   = {8'h0, 4'h3};
    bus.DataIn   = 32'h1234_5678;
    exp_q.push_back(mk(32'hA5A5_0001, 4'h3, 3'b001, 1'b0, 32'h1234_5678));
    bus.req = 3'b001;
    wait_start("t1");
    bus.req      = '0;
    bus.req_data = {64'h0, 32'h0BAD_0BAD};
    bus.req_wr   = {8'h0, 4'hE};
    drain("t1");

    // Minimum latency through requester 1's slices
    busy_len     = 1;
    bus.req_data = {32'h0, 32'hCAFE_0002, 32'h0};
    bus.req_wr   = {4'h0, 4'hA, 4'h0};
    bus.DataIn   = 32'hCAFE_F00D;
    exp_q.push_back(mk(32'hCAFE_0002, 4'hA, 3'b010, 1'b0, 32'hCAFE_F00D));
    req_and_count(3'b010, lat);
    chk("min_latency", 72'(lat), 72'd4);
    drain("t2");

    // All three requesting: round-robin 0,1,2, back to back
    do_reset();
    bus.req_data = DATA3;
    bus.req_wr   = WR3;
    bus.DataIn   = 32'h5555_AAAA;
    done_cyc_q.delete();
    exp_q.push_back(mk(32'hC0DE_0000, 4'h5, 3'b001, 1'b0, 32'h5555_AAAA));
    exp_q.push_back(mk(32'hC0DE_0001, 4'h6, 3'b010, 1'b0, 32'h5555_AAAA));
    exp_q.push_back(mk(32'hC0DE_0002, 4'h9, 3'b100, 1'b0, 32'h5555_AAAA));
    @(negedge clk);
    bus.req = 3'b111;
    for (int i = 0; i < 3; i++) wait_start("t3");
    bus.req = '0;
    drain("t3");
    chk("rr_done_count", 72'(done_cyc_q.size()), 72'd3);
    if (done_cyc_q.size() == 3) begin
      d0 = done_cyc_q[0];
      d1 = done_cyc_q[1];
      d2 = done_cyc_q[2];
      chk("b2b_gap_01", 72'(d1 - d0), 72'd5);
      chk("b2b_gap_12", 72'(d2 - d1), 72'd5);
    end

    // Burst lock on requester 1 while requester 2 also waits
    do_reset();
    bus.DataIn = 32'h3636_0000;
    exp_q.push_back(mk(32'hC0DE_0001, 4'h6, 3'b010, 1'b0, 32'h3636_0000));
    exp_q.push_back(mk(32'hC0DE_0001, 4'h6, 3'b010, 1'b0, 32'h3636_0000));
    exp_q.push_back(mk(32'hC0DE_0001, 4'h6, 3'b010, 1'b0, 32'h3636_0000));
    exp_q.push_back(mk(32'hC0DE_0002, 4'h9, 3'b100, 1'b0, 32'h3636_0000));
    @(negedge clk);
    bus.lock = 3'b010;
    bus.req  = 3'b110;
    for (int i = 0; i < 3; i++) wait_start("t4");
    bus.lock = 3'b000;
    wait_start("t4");
    bus.req = '0;
    drain("t4");

    // Timeout in WAIT_BUSY: Busy never rises
    busy_len   = 0;
    bus.DataIn = 32'hDEAD_BEEF;
    exp_q.push_back(mk(32'hC0DE_0000, 4'h5, 3'b001, 1'b1, 32'h3636_0000));
    req_and_count(3'b001, lat);
    chk("timeout_busy_latency", 72'(lat), 72'd10);
    drain("t5");

    // Timeout in WAIT_DONE: Busy never falls
    busy_len = 20;
    exp_q.push_back(mk(32'hC0DE_0000, 4'h5, 3'b001, 1'b1, 32'h3636_0000));
    req_and_count(3'b001, lat);
    chk("timeout_done_latency", 72'(lat), 72'd11);
    drain("t6");
    repeat (20) @(negedge clk);

    // Busy already high in IDLE must not block the grant
    busy_len    = 1;
    busy_manual = 1'b1;
    spi_auto    = 1'b0;
    repeat (2) @(negedge clk);
    bus.DataIn = 32'h7777_0030;
    exp_q.push_back(mk(32'hC0DE_0002, 4'h9, 3'b100, 1'b0, 32'h7777_0030));
    bus.req = 3'b100;
    wait_start("t7");
    bus.req = '0;
    @(posedge clk);
    @(posedge clk);
    #1 busy_manual = 1'b0;
    drain("t7");
    spi_auto = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in WAIT_DONE aborts without done, then 101 grants requester 0
    busy_len = 5;
    exp_q.push_back(mk(32'hC0DE_0000, 4'h5, 3'b001, 1'b0, 32'h0));
    bus.req = 3'b001;
    wait_start("t8");
    bus.req = '0;
    repeat (2) @(negedge clk);
    chk("t8_in_wait_done", dbg_state, 3'd3);
    rstn = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk_outputs_zero("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    bus.DataIn = 32'h0808_0808;
    exp_q.push_back(mk(32'hC0DE_0000, 4'h5, 3'b001, 1'b0, 32'h0808_0808));
    bus.req = 3'b101;
    wait_start("t8b");
    bus.req = '0;
    drain("t8b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cc1200_spi_arbiter.md
CC1200_SPI_ARBITER -- requirements
Module: cc1200_spi_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1000, SHALL set the maximum cycles allowed in each of WAIT_BUSY and WAIT_DONE before the transaction is aborted (range 1..65535).
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rstn  input  1  reset, synchronous and active-low.
REQ-004 req  input  3  per-requester transaction request (bit 0 APB software, bit 1 Tx packet engine, bit 2 Rx packet engine).
REQ-005 req_data  input  96  32-bit SPI word per requester; requester i uses bits [32i+31:32i].
REQ-006 req_wr  input  12  4-bit WR code per requester; requester i uses bits [4i+3:4i].
REQ-007 lock  input  3  per-requester burst lock; holds ownership across back-to-back transactions.
REQ-008 gnt  output  3  one-hot owner of the SPI engine; all zero when idle.
REQ-009 done  output  3  one-cycle completion pulse to the owning requester.
REQ-010 err  output  1  one-cycle pulse coincident with done when the transaction timed out.
REQ-011 rdata  output  32  DataIn captured at completion; shared by all requesters.
REQ-012 Start  output  1  one-cycle start pulse to the SPI engine.
REQ-013 Busy  input  1  SPI engine busy flag.
REQ-014 DataOut  output  32  word driven to the SPI engine.
REQ-015 WR  output  4  WR code driven to the SPI engine.
REQ-016 DataIn  input  32  word returned by the SPI engine.

Function
REQ-017 The FSM SHALL have the states IDLE, START, WAIT_BUSY, WAIT_DONE and DONE.
REQ-018 In IDLE with req nonzero, the FSM SHALL select the winner, set gnt, register DataOut/WR from the winner's req_data/req_wr, and move to START on the next edge.
REQ-019 Arbitration: if lock[last] and req[last] are both high, last SHALL win; otherwise round-robin SHALL search (last+1) mod 3, (last+2) mod 3, last, and the first set bit SHALL win.
REQ-020 last SHALL update to the winner at each grant.
REQ-021 START SHALL assert Start for exactly one cycle, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY: Busy=1 SHALL move the FSM to WAIT_DONE and clear the timeout counter.
REQ-023 WAIT_DONE: Busy=0 SHALL move the FSM to DONE.
REQ-024 The 16-bit timeout counter SHALL increment each cycle in WAIT_BUSY and WAIT_DONE; on reaching TIMEOUT, the FSM SHALL go to DONE with the error flag set.
REQ-025 DONE SHALL last one cycle: done[owner]=1, err=error flag, rdata<=DataIn (rdata unchanged on error), gnt cleared on exit, then return to IDLE.
REQ-026 Minimum latency from grant to done SHALL be 4 cycles (IDLE->START->WAIT_BUSY->WAIT_DONE->DONE, Busy high for 1 cycle).
REQ-027 Back-to-back: a request present in the IDLE cycle after DONE SHALL be granted; there SHALL be no dead cycle beyond that IDLE.
REQ-028 A requester dropping req after grant SHALL NOT abort the transaction; done SHALL still pulse.
REQ-029 req_data/req_wr changes after grant SHALL be ignored, because DataOut and WR are held registered until the next grant.
REQ-030 Busy already high in IDLE SHALL NOT block the grant; WAIT_BUSY SHALL see it immediately and advance.
REQ-031 Simultaneous requests SHALL produce exactly one grant bit; gnt and done SHALL always be one-hot or zero.

Reset
REQ-032 While rstn=0 at a clock edge: state SHALL become IDLE, last SHALL become 2 (first search starts at requester 0), and counter, gnt, done, err, Start, DataOut, WR and rdata SHALL all become zero.
REQ-033 Reset mid-transaction SHALL abort without a done pulse; Start SHALL be low from the first reset edge.

Verification
REQ-034 req=3'b001, req_data[31:0]=32'hA5A5_0001, req_wr[3:0]=4'h3, Busy high for 5 cycles after Start, DataIn=32'h1234_5678 -> gnt=001, one Start pulse, DataOut=A5A50001, WR=3, done=001, rdata=12345678, err=0.
REQ-035 req=3'b111 held constant through three transactions after reset -> grant order 0,1,2, each with exactly one done pulse.
REQ-036 lock[1]=1 and req[1] re-asserted with req[2]=1 -> requester 1 is regranted twice in a row; after lock[1] drops, requester 2 is granted next.
REQ-037 TIMEOUT=8, Busy held at 0 -> after 8 cycles in WAIT_BUSY, done and err pulse together, rdata is unchanged, and the FSM returns to IDLE.
REQ-038 rstn=0 asserted in WAIT_DONE -> no done pulse; on the next edge all outputs are zero; after release, req=3'b101 grants requester 0 first.
